// File: rtl/spec_issue_scheduler_pkg.sv
// spec_issue_scheduler_pkg: shared field positions and FSM state encoding.
// Exports DST_LSB, SRC2_LSB, SRC1_LSB (instruction byte fields), MC_CLASS_HI/LO
// (multi-cycle class bits of the micro-code word) and state_t {IDLE, HELD}.
package spec_issue_scheduler_pkg;
   localparam int DST_LSB     = 0;
   localparam int SRC2_LSB    = 8;
   localparam int SRC1_LSB    = 16;
   localparam int MC_CLASS_HI = 11;
   localparam int MC_CLASS_LO = 5;
   typedef enum logic {IDLE, HELD} state_t;
endpackage

// File: rtl/spec_pair_conflict_check.sv
// spec_pair_conflict_check: decides whether a normal and a speculative op may dual-issue.
// Ports: norm_micro_code/norm_instr, spec_micro_code/spec_instr (in, 32 each);
// conflict (out) is high on shared resource, multi-cycle normal op, or spec source reading norm dest.
module spec_pair_conflict_check
   import spec_issue_scheduler_pkg::*;
(
   input  logic [31:0] norm_micro_code,
   input  logic [31:0] norm_instr,
   input  logic [31:0] spec_micro_code,
   input  logic [31:0] spec_instr,
   output logic        conflict
);
   logic [7:0] dst;
   logic       unused_bits;
   assign dst = norm_instr[DST_LSB +: 8];
   assign conflict = |(spec_micro_code & norm_micro_code)
                   | |norm_micro_code[MC_CLASS_HI:MC_CLASS_LO]
                   | (spec_instr[SRC1_LSB +: 8] == dst)
                   | (spec_instr[SRC2_LSB +: 8] == dst);
   assign unused_bits = ^{norm_instr[31:8], spec_instr[31:24], spec_instr[7:0]};
endmodule

// File: rtl/spec_issue_scheduler.sv
// spec_issue_scheduler: dual-slot issue controller pairing normal and speculative micro-ops.
// Ports: clk, rst (async, active high); norm_* / spec_* valid-ready inputs; flush kills
// speculative state; stall freezes issue; issue0_*/issue1_* registered issue slots;
// pair_count / defer_count wrapping statistics.
module spec_issue_scheduler
   import spec_issue_scheduler_pkg::*;
#(
   parameter int unsigned BLOCK_CYCLES = 3,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             norm_valid,
   input  logic [31:0]      norm_micro_code,
   input  logic [31:0]      norm_instr,
   output logic             norm_ready,
   input  logic             spec_valid,
   input  logic [31:0]      spec_micro_code,
   input  logic [31:0]      spec_instr,
   output logic             spec_ready,
   input  logic             flush,
   input  logic             stall,
   output logic             issue0_valid,
   output logic [31:0]      issue0_micro_code,
   output logic [31:0]      issue0_instr,
   output logic             issue1_valid,
   output logic [31:0]      issue1_micro_code,
   output logic [31:0]      issue1_instr,
   output logic [CNT_W-1:0] pair_count,
   output logic [CNT_W-1:0] defer_count
);
   localparam logic [3:0] BLK = 4'(BLOCK_CYCLES);
   state_t      state, state_nx;
   logic        conflict, acc_n, acc_s, defer, pair, multi;
   logic [3:0]  wait_cnt;
   logic [31:0] hold_mc, hold_instr;

   spec_pair_conflict_check u_conflict (
      .norm_micro_code (norm_micro_code),
      .norm_instr      (norm_instr),
      .spec_micro_code (spec_micro_code),
      .spec_instr      (spec_instr),
      .conflict        (conflict)
   );

   assign acc_n = norm_valid & norm_ready;
   assign acc_s = spec_valid & spec_ready;
   assign pair  = acc_n & acc_s & ~conflict;
   assign defer = acc_n & acc_s & conflict;
   assign multi = |norm_micro_code[MC_CLASS_HI:MC_CLASS_LO];

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   // Flush leaves HELD even under stall; otherwise HELD exits on the last wait cycle.
   always_comb
      state_nx = (state == HELD) ? ((flush | (~stall & wait_cnt <= 4'd1)) ? IDLE : HELD)
                                 : (defer ? HELD : IDLE);

   always_comb begin
      norm_ready = ~stall & (state == IDLE);
      spec_ready = ~stall & (state == IDLE) & ~flush;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         issue0_valid      <= 1'b0;
         issue0_micro_code <= '0;
         issue0_instr      <= '0;
         issue1_valid      <= 1'b0;
         issue1_micro_code <= '0;
         issue1_instr      <= '0;
         hold_mc           <= '0;
         hold_instr        <= '0;
         wait_cnt          <= '0;
         pair_count        <= '0;
         defer_count       <= '0;
      end else begin
         if (state == HELD && flush) begin
            wait_cnt   <= '0;
            hold_mc    <= '0;
            hold_instr <= '0;
         end
         if (!stall) begin
            if (state == HELD) begin
               issue0_valid      <= ~flush & (wait_cnt == 4'd1);
               issue0_micro_code <= hold_mc;
               issue0_instr      <= hold_instr;
               issue1_valid      <= 1'b0;
               if (!flush) wait_cnt <= wait_cnt - 4'd1;
            end else begin
               issue0_valid      <= acc_n | acc_s;
               issue0_micro_code <= acc_n ? norm_micro_code : spec_micro_code;
               issue0_instr      <= acc_n ? norm_instr : spec_instr;
               issue1_valid      <= pair;
               issue1_micro_code <= spec_micro_code;
               issue1_instr      <= spec_instr;
               if (pair) pair_count <= pair_count + 1'b1;
               if (defer) begin
                  hold_mc     <= spec_micro_code;
                  hold_instr  <= spec_instr;
                  wait_cnt    <= multi ? BLK : 4'd1;
                  defer_count <= defer_count + 1'b1;
               end
            end
         end
      end
endmodule

// File: doc/spec_issue_scheduler.md
Name: spec_issue_scheduler

Overview:
- Dual-slot issue controller placed between micro-code fetch and execute.
- Pairs each normal micro-op with a speculatively fetched micro-op when the two do not conflict.
- On conflict, issues the normal op and parks the speculative op in a one-entry holding register. The parked op issues alone once its wait count expires.
- Supports downstream stall and speculative flush (branch mispredict).

Parameters:
- BLOCK_CYCLES, 3, hold cycles for a parked op when the normal op is multi-cycle class (norm_micro_code[11:5] != 0); legal range 1..15.
- CNT_W, 16, width of the pair/defer statistics counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- norm_valid  in  1  normal micro-op offered
- norm_micro_code  in  32  normal micro-code word (resource one-hot bits; [11:5] = multi-cycle class)
- norm_instr  in  32  normal instruction; [7:0] = destination register
- norm_ready  out  1  normal op accepted when norm_valid & norm_ready
- spec_valid  in  1  speculative micro-op offered
- spec_micro_code  in  32  speculative micro-code word
- spec_instr  in  32  speculative instruction; [23:16] = src1, [15:8] = src2
- spec_ready  out  1  speculative op accepted when spec_valid & spec_ready
- flush  in  1  kill all speculative state
- stall  in  1  downstream stall; all issue outputs hold
- issue0_valid / issue0_micro_code / issue0_instr  out  1/32/32  primary issue slot
- issue1_valid / issue1_micro_code / issue1_instr  out  1/32/32  secondary (paired) issue slot
- pair_count  out  CNT_W  number of dual issues, wraps
- defer_count  out  CNT_W  number of parked speculative ops, wraps

Behaviour:
- Reset: state = IDLE; all issue outputs, the hold register, the wait counter and both stat counters = 0.
- Conflict = |(spec_mc & norm_mc) | |norm_mc[11:5] | (spec_instr[23:16] == norm_instr[7:0]) | (spec_instr[15:8] == norm_instr[7:0]). Purely combinational.
- Handshakes:
  - norm_ready = ~stall & (state == IDLE).
  - spec_ready = ~stall & (state == IDLE) & ~flush.
- Issue outputs are registered (1-cycle latency from acceptance). When stall=1, issue regs, state and wait counter all freeze.
- IDLE, stall=0, next-cycle issue per accepted inputs:
  - norm & spec, no conflict: slot0 = norm, slot1 = spec; pair_count++.
  - norm & spec, conflict: slot0 = norm; spec goes to the hold reg; state -> HELD; defer_count++.
    - wait = BLOCK_CYCLES if norm_mc[11:5] != 0, else 1.
  - norm only: slot0 = norm, slot1 invalid.
  - spec only: slot0 = spec (no partner, so no conflict possible).
  - none: both slots invalid.
- HELD, stall=0:
  - Both slots invalid while wait > 1; wait decrements each cycle.
  - When wait == 1: slot0 = held op; state -> IDLE next cycle.
  - No new inputs are accepted in HELD.
- Flush:
  - In IDLE, the same-cycle spec input is not accepted; norm is processed normally, with no pairing.
  - In HELD, the held op is discarded, wait is cleared, and state -> IDLE next edge, even if stall=1.
  - Already-registered issue slots are not retracted.
- Reset mid-HELD: the held op is lost; outputs clear immediately (asynchronous reset).
- Counters wrap at 2^CNT_W with no saturation.

Decomposition:
- Shared package: field position constants (DST_LSB = 0, SRC2_LSB = 8, SRC1_LSB = 16, MC_CLASS_HI = 11, MC_CLASS_LO = 5) and the state enum {IDLE, HELD}.
- One sub-module, spec_pair_conflict_check: combinational conflict predicate from the four 32-bit words.

Test Plan:
1. norm_mc = 0x0001, dst = 0x05; spec_mc = 0x0002, src = 0x01/0x02 -> next cycle issue0 = norm, issue1 = spec; pair_count = 1.
2. norm_mc = 0x0003, spec_mc = 0x0002 (resource overlap) -> issue0 = norm, issue1 invalid; the following cycle issue0 = spec; defer_count = 1; norm_ready low for 1 cycle.
3. norm_mc = 0x0020 (bit 5, multi-cycle), BLOCK_CYCLES = 3 -> spec appears on issue0 exactly 3 cycles after norm issues; both slots idle in between.
4. spec_instr[15:8] = 0x07, norm dst = 0x07, no resource overlap -> deferred (register dependency detected).
5. Park spec, then assert flush one cycle later -> held op never issues; state IDLE; spec_ready high again next cycle.
6. Pairable inputs with stall = 1 for 2 cycles -> ready low, issue regs unchanged; pair issues on the cycle after stall drops. Reset asserted mid-HELD -> all outputs 0 immediately.
